// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding mux plus load-use stall FSM.
// Optional macro FWD_WB_EN adds WB-stage forwarding and hold-time capture registers.
`default_nettype none

module fwd_hazard_unit #(
   parameter int XLEN     = 32,
   parameter int NREAD    = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREAD*5-1:0]    rs_addr_ID,
   input  logic [NREAD*5-1:0]    rs_addr_EX,
   input  logic [NREAD*XLEN-1:0] read_EX,
   input  logic [4:0]            rd_MEM,
   input  logic                  wen_MEM,
   input  logic                  load_MEM,
   input  logic [XLEN-1:0]       alu_MEM,
   input  logic [4:0]            rd_WB,
   input  logic                  wen_WB,
   input  logic [XLEN-1:0]       data_WB,
   input  logic [4:0]            rd_EX,
   input  logic                  wen_EX,
   input  logic                  load_EX,
   input  logic                  ex_hold,
   input  logic                  flush_EX,
   output logic [NREAD*XLEN-1:0] read_EX_pro,
   output logic                  stall_ID,
   output logic                  bubble_EX
);

   localparam logic [0:0] c_S_IDLE   = 1'b0;
   localparam logic [0:0] c_S_STALL  = 1'b1;
   localparam logic [1:0] c_CNT_INIT = 2'(LOAD_LAT - 1);
   localparam bit         c_MULTI    = (LOAD_LAT > 1);

   logic [0:0] r_state;
   logic [1:0] r_cnt;
   logic       w_hazard;
   logic       w_fsm_stall;
   logic [4:0] w_rs;

   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         if (rs_addr_ID[i*5 +: 5] == rd_EX) w_hazard = 1'b1;
      end
      w_hazard = w_hazard & wen_EX & load_EX & (rd_EX != 5'd0);
   end

   assign w_fsm_stall = (r_state == c_S_STALL) | w_hazard;
   // Outputs are gated by reset so they drop the instant rst_n falls.
   assign stall_ID    = rst_n & ~flush_EX & (w_fsm_stall | ex_hold);
   assign bubble_EX   = rst_n & ~flush_EX & w_fsm_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_S_IDLE;
         r_cnt   <= 2'd0;
      end else if (flush_EX) begin
         r_state <= c_S_IDLE;
         r_cnt   <= 2'd0;
      end else if (!ex_hold) begin
         case (r_state)
            c_S_IDLE: begin
               if (w_hazard && c_MULTI) begin
                  r_state <= c_S_STALL;
                  r_cnt   <= c_CNT_INIT;
               end
            end
            default: begin
               // The IDLE detection cycle is the first bubble; leave once the count is spent.
               if (r_cnt <= 2'd1) begin
                  r_state <= c_S_IDLE;
                  r_cnt   <= 2'd0;
               end else begin
                  r_cnt   <= r_cnt - 2'd1;
               end
            end
         endcase
      end
   end

`ifdef FWD_WB_EN
   logic            r_cap_vld  [NREAD];
   logic [XLEN-1:0] r_cap_data [NREAD];

   generate
      for (genvar gi = 0; gi < NREAD; gi++) begin : g_cap
         logic [4:0] w_rs_cap;
         assign w_rs_cap = rs_addr_EX[gi*5 +: 5];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cap_vld[gi]  <= 1'b0;
               r_cap_data[gi] <= '0;
            end else if (flush_EX || !ex_hold) begin
               r_cap_vld[gi]  <= 1'b0;
            end else if (!r_cap_vld[gi] && wen_WB && (rd_WB == w_rs_cap) && (w_rs_cap != 5'd0)) begin
               r_cap_vld[gi]  <= 1'b1;
               r_cap_data[gi] <= data_WB;
            end
         end
      end
   endgenerate
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{rd_WB, wen_WB, data_WB};
`endif

   always_comb begin
      read_EX_pro = read_EX;
      w_rs        = 5'd0;
      for (int i = 0; i < NREAD; i++) begin
         w_rs = rs_addr_EX[i*5 +: 5];
`ifdef FWD_WB_EN
         if (r_cap_vld[i]) begin
            read_EX_pro[i*XLEN +: XLEN] = r_cap_data[i];
         end else if (w_rs != 5'd0 && wen_MEM && !load_MEM && rd_MEM == w_rs) begin
            read_EX_pro[i*XLEN +: XLEN] = alu_MEM;
         end else if (w_rs != 5'd0 && wen_WB && rd_WB == w_rs) begin
            read_EX_pro[i*XLEN +: XLEN] = data_WB;
         end
`else
         if (w_rs != 5'd0 && wen_MEM && !load_MEM && rd_MEM == w_rs) begin
            read_EX_pro[i*XLEN +: XLEN] = alu_MEM;
         end
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vector table plus hand sequences for stall, hold, flush and reset.
`default_nettype none

module tb_fwd_hazard_unit;

`ifdef FWD_WB_EN
   localparam bit c_WB = 1'b1;
`else
   localparam bit c_WB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rs_addr_ID, rs_addr_EX;
   logic [63:0] read_EX;
   logic [4:0]  rd_MEM, rd_WB, rd_EX;
   logic        wen_MEM, load_MEM, wen_WB, wen_EX, load_EX, ex_hold, flush_EX;
   logic [31:0] alu_MEM, data_WB;
   logic [63:0] read_EX_pro;
   logic        stall_ID, bubble_EX;

   int n_vec = 0;
   int n_bad = 0;

   fwd_hazard_unit #(.XLEN(32), .NREAD(2), .LOAD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_addr_ID(rs_addr_ID), .rs_addr_EX(rs_addr_EX), .read_EX(read_EX),
      .rd_MEM(rd_MEM), .wen_MEM(wen_MEM), .load_MEM(load_MEM), .alu_MEM(alu_MEM),
      .rd_WB(rd_WB), .wen_WB(wen_WB), .data_WB(data_WB),
      .rd_EX(rd_EX), .wen_EX(wen_EX), .load_EX(load_EX),
      .ex_hold(ex_hold), .flush_EX(flush_EX),
      .read_EX_pro(read_EX_pro), .stall_ID(stall_ID), .bubble_EX(bubble_EX)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  rs_ex;
      logic [63:0] rd;
      logic [4:0]  rd_mem;
      logic        wen_mem, load_mem;
      logic [31:0] alu;
      logic [4:0]  rd_wb;
      logic        wen_wb;
      logic [31:0] dwb;
      logic [9:0]  rs_id;
      logic [4:0]  rd_ex;
      logic        wen_ex, load_ex;
      logic [63:0] exp_wb, exp_nowb;
      logic        exp_stall;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic [9:0] rs_ex, logic [63:0] rd,
                               logic [4:0] rd_mem, logic wen_mem, logic load_mem, logic [31:0] alu,
                               logic [4:0] rd_wb, logic wen_wb, logic [31:0] dwb,
                               logic [9:0] rs_id, logic [4:0] rd_ex, logic wen_ex, logic load_ex,
                               logic [63:0] exp_wb, logic [63:0] exp_nowb, logic exp_stall);
      vec_t v;
      v.rs_ex = rs_ex; v.rd = rd;
      v.rd_mem = rd_mem; v.wen_mem = wen_mem; v.load_mem = load_mem; v.alu = alu;
      v.rd_wb = rd_wb; v.wen_wb = wen_wb; v.dwb = dwb;
      v.rs_id = rs_id; v.rd_ex = rd_ex; v.wen_ex = wen_ex; v.load_ex = load_ex;
      v.exp_wb = exp_wb; v.exp_nowb = exp_nowb; v.exp_stall = exp_stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_hazard(input logic on);
      rs_addr_ID = on ? {5'd7, 5'd1} : 10'd0;
      rd_EX      = on ? 5'd7 : 5'd0;
      wen_EX     = on;
      load_EX    = on;
   endtask

   task automatic clear_all();
      rs_addr_ID = '0; rs_addr_EX = '0; read_EX = '0;
      rd_MEM = '0; wen_MEM = 0; load_MEM = 0; alu_MEM = '0;
      rd_WB = '0; wen_WB = 0; data_WB = '0;
      rd_EX = '0; wen_EX = 0; load_EX = 0; ex_hold = 0; flush_EX = 0;
   endtask

   initial begin
      logic [63:0] exp;
      //                rs_ex          read                      MEM: rd wen ld alu         WB: rd wen data       ID/EX: rs_id rd wen ld     exp_wb                  exp_nowb                stall
      tbl[0]  = mk({5'd2,5'd1},  {32'hB,32'hA},         5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    10'd0,        5'd0,0,0, {32'hB,32'hA},        {32'hB,32'hA},        0);
      tbl[1]  = mk({5'd6,5'd5},  {32'h66,32'h55},       5'd5, 1,0,32'h11,    5'd5, 1,32'h22,   10'd0,        5'd0,0,0, {32'h66,32'h11},      {32'h66,32'h11},      0);
      tbl[2]  = mk({5'd3,5'd4},  {32'h300,32'h400},     5'd3, 1,0,32'h33,    5'd0, 0,32'h0,    10'd0,        5'd0,0,0, {32'h33,32'h400},     {32'h33,32'h400},     0);
      tbl[3]  = mk({5'd1,5'd4},  {32'h100,32'h400},     5'd4, 1,1,32'h77,    5'd4, 1,32'h44,   10'd0,        5'd0,0,0, {32'h100,32'h44},     {32'h100,32'h400},    0);
      tbl[4]  = mk({5'd8,5'd8},  {32'h800,32'h801},     5'd0, 0,0,32'h0,     5'd8, 1,32'h88,   10'd0,        5'd0,0,0, {32'h88,32'h88},      {32'h800,32'h801},    0);
      tbl[5]  = mk({5'd1,5'd10}, {32'h1,32'h2},         5'd10,0,0,32'h99,    5'd0, 0,32'h0,    10'd0,        5'd0,0,0, {32'h1,32'h2},        {32'h1,32'h2},        0);
      tbl[6]  = mk({5'd0,5'd0},  {32'hC,32'hD},         5'd0, 1,0,32'hFFFF,  5'd0, 1,32'h1234, 10'd0,        5'd0,0,0, {32'hC,32'hD},        {32'hC,32'hD},        0);
      tbl[7]  = mk({5'd12,5'd0}, {32'hE,32'hF},         5'd0, 0,0,32'h0,     5'd12,0,32'h5,    10'd0,        5'd0,0,0, {32'hE,32'hF},        {32'hE,32'hF},        0);
      tbl[8]  = mk({5'd13,5'd14},{32'h1,32'h2},         5'd14,1,0,32'hAA,    5'd13,1,32'hBB,   10'd0,        5'd0,0,0, {32'hBB,32'hAA},      {32'h1,32'hAA},       0);
      tbl[9]  = mk(10'd0,        64'h0,                 5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    {5'd7,5'd1},  5'd7,1,1, 64'h0,                64'h0,                1);
      tbl[10] = mk(10'd0,        64'h0,                 5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    {5'd2,5'd9},  5'd9,1,1, 64'h0,                64'h0,                1);
      tbl[11] = mk(10'd0,        64'h0,                 5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    {5'd0,5'd0},  5'd0,1,1, 64'h0,                64'h0,                0);
      tbl[12] = mk(10'd0,        64'h0,                 5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    {5'd7,5'd7},  5'd7,1,0, 64'h0,                64'h0,                0);
      tbl[13] = mk(10'd0,        64'h0,                 5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    {5'd7,5'd7},  5'd7,0,1, 64'h0,                64'h0,                0);
      tbl[14] = mk(10'd0,        64'h0,                 5'd0, 0,0,32'h0,     5'd0, 0,32'h0,    {5'd3,5'd4},  5'd5,1,1, 64'h0,                64'h0,                0);

      // Reset with a live hazard on the inputs: outputs must stay low.
      clear_all();
      rst_n = 1'b0;
      set_hazard(1'b1);
      #12;
      chk("reset_stall", {63'd0, stall_ID}, 64'd0);
      chk("reset_bubble", {63'd0, bubble_EX}, 64'd0);
      @(negedge clk);
      clear_all();
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rs_addr_EX = tbl[i].rs_ex;  read_EX  = tbl[i].rd;
         rd_MEM  = tbl[i].rd_mem;    wen_MEM  = tbl[i].wen_mem;
         load_MEM = tbl[i].load_mem; alu_MEM  = tbl[i].alu;
         rd_WB   = tbl[i].rd_wb;     wen_WB   = tbl[i].wen_wb;  data_WB = tbl[i].dwb;
         rs_addr_ID = tbl[i].rs_id;  rd_EX    = tbl[i].rd_ex;
         wen_EX  = tbl[i].wen_ex;    load_EX  = tbl[i].load_ex;
         #1;
         exp = c_WB ? tbl[i].exp_wb : tbl[i].exp_nowb;
         chk($sformatf("vec%0d_pro", i), read_EX_pro, exp);
         chk($sformatf("vec%0d_stall", i), {63'd0, stall_ID}, {63'd0, tbl[i].exp_stall});
         chk($sformatf("vec%0d_bubble", i), {63'd0, bubble_EX}, {63'd0, tbl[i].exp_stall});
         // Flush across the edge so every vector starts from IDLE.
         flush_EX = 1'b1;
         @(posedge clk); #1;
         clear_all();
      end

      // Load-use with LOAD_LAT=2: exactly two stall cycles.
      @(negedge clk);
      set_hazard(1'b1);
      #1;
      chk("lu_c0_stall", {63'd0, stall_ID}, 64'd1);
      chk("lu_c0_bubble", {63'd0, bubble_EX}, 64'd1);
      @(posedge clk); #1;
      set_hazard(1'b0);
      #1;
      chk("lu_c1_stall", {63'd0, stall_ID}, 64'd1);
      chk("lu_c1_bubble", {63'd0, bubble_EX}, 64'd1);
      @(posedge clk); #1;
      chk("lu_c2_stall", {63'd0, stall_ID}, 64'd0);
      chk("lu_c2_bubble", {63'd0, bubble_EX}, 64'd0);
      @(posedge clk); #1;
      chk("lu_c3_stall", {63'd0, stall_ID}, 64'd0);

      // ex_hold alone stalls ID without a bubble, and freezes a pending stall.
      ex_hold = 1'b1;
      #1;
      chk("hold_idle_stall", {63'd0, stall_ID}, 64'd1);
      chk("hold_idle_bubble", {63'd0, bubble_EX}, 64'd0);
      ex_hold = 1'b0;
      @(negedge clk);
      set_hazard(1'b1);
      @(posedge clk); #1;
      set_hazard(1'b0);
      ex_hold = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("hold_frozen_bubble", {63'd0, bubble_EX}, 64'd1);
      ex_hold = 1'b0;
      #1;
      chk("hold_release_bubble", {63'd0, bubble_EX}, 64'd1);
      @(posedge clk); #1;
      chk("hold_done_stall", {63'd0, stall_ID}, 64'd0);

      // Flush mid-stall, then flush against a fresh hazard.
      @(negedge clk);
      set_hazard(1'b1);
      @(posedge clk); #1;
      set_hazard(1'b0);
      flush_EX = 1'b1;
      #1;
      chk("flush_stall", {63'd0, stall_ID}, 64'd0);
      chk("flush_bubble", {63'd0, bubble_EX}, 64'd0);
      @(posedge clk); #1;
      flush_EX = 1'b0;
      #1;
      chk("flush_next_stall", {63'd0, stall_ID}, 64'd0);
      set_hazard(1'b1);
      flush_EX = 1'b1;
      #1;
      chk("flush_over_hazard", {63'd0, stall_ID}, 64'd0);
      @(posedge clk); #1;
      set_hazard(1'b0);
      flush_EX = 1'b0;
      #1;
      chk("flush_no_stall_entry", {63'd0, bubble_EX}, 64'd0);

      // Asynchronous reset in the middle of a stall.
      @(negedge clk);
      set_hazard(1'b1);
      @(posedge clk); #1;
      set_hazard(1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_stall", {62'd0, stall_ID, bubble_EX}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_release", {62'd0, stall_ID, bubble_EX}, 64'd0);
      @(posedge clk); #1;
      chk("rst_no_residual", {62'd0, stall_ID, bubble_EX}, 64'd0);

      // WB value written during a hold is kept for the held instruction.
      @(negedge clk);
      clear_all();
      ex_hold    = 1'b1;
      rs_addr_EX = {5'd9, 5'd0};
      read_EX    = {32'h1111, 32'h0};
      rd_WB = 5'd9; wen_WB = 1'b1; data_WB = 32'hABCD;
      #1;
      chk("cap_c1", read_EX_pro, {(c_WB ? 32'hABCD : 32'h1111), 32'h0});
      @(posedge clk); #1;
      data_WB = 32'h5555;
      #1;
      chk("cap_c2", read_EX_pro, {(c_WB ? 32'hABCD : 32'h1111), 32'h0});
      @(posedge clk); #1;
      wen_WB = 1'b0; data_WB = 32'hDEAD;
      #1;
      chk("cap_c3", read_EX_pro, {(c_WB ? 32'hABCD : 32'h1111), 32'h0});
      @(posedge clk); #1;
      ex_hold = 1'b0;
      #1;
      chk("cap_release", read_EX_pro, {(c_WB ? 32'hABCD : 32'h1111), 32'h0});
      @(posedge clk); #1;
      chk("cap_cleared", read_EX_pro, {32'h1111, 32'h0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL take parameter XLEN, default 32: operand/data width.
REQ-002 The block SHALL take parameter NREAD, default 2: number of EX source operands, 1..4.
REQ-003 The block SHALL take parameter LOAD_LAT, default 1: load-use bubble cycles, 1..4.
REQ-004 The block SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 The block SHALL have port rs_addr_ID  in  NREAD*5: source register addresses of the instruction in ID.
REQ-007 The block SHALL have port rs_addr_EX  in  NREAD*5: source register addresses of the instruction in EX.
REQ-008 The block SHALL have port read_EX  in  NREAD*XLEN: register-file values latched into EX.
REQ-009 The block SHALL have ports rd_MEM (5), wen_MEM (1), load_MEM (1), alu_MEM (XLEN)  in: MEM-stage producer.
REQ-010 The block SHALL have ports rd_WB (5), wen_WB (1), data_WB (XLEN)  in: WB-stage producer.
REQ-011 The block SHALL have ports rd_EX (5), wen_EX (1), load_EX (1)  in: EX-stage producer.
REQ-012 The block SHALL have port ex_hold  in  1: EX held (multi-cycle op); flush_EX  in  1: taken branch/jump in EX.
REQ-013 The block SHALL have port read_EX_pro  out  NREAD*XLEN: forwarded operands.
REQ-014 The block SHALL have ports stall_ID  out  1 (hold PC, IF/ID) and bubble_EX  out  1 (insert NOP into ID/EX).

Function
REQ-015 Per port i, read_EX_pro SHALL select, in priority: captured value (REQ-020), alu_MEM if wen_MEM & !load_MEM & rd_MEM==rs, data_WB if wen_WB & rd_WB==rs, else read_EX.
REQ-016 A source address of 0 SHALL never be forwarded; read_EX_pro is read_EX for that port.
REQ-017 Load-use hazard SHALL be: wen_EX & load_EX & rd_EX!=0 & rd_EX equals any rs_addr_ID port.
REQ-018 FSM states SHALL be IDLE and STALL with a 2-bit counter; IDLE on hazard asserts stall_ID and bubble_EX combinationally the same cycle, enters STALL with counter=LOAD_LAT-1 if LOAD_LAT>1, else stays IDLE.
REQ-019 In STALL, stall_ID and bubble_EX SHALL be 1, counter decrements each cycle, return to IDLE when counter is 0 at the clock edge; total bubbles = LOAD_LAT.
REQ-020 While ex_hold=1, if WB writes a register matching port i (nonzero) and no capture is valid, value SHALL be latched into capture register i with valid set; cleared on the first cycle ex_hold=0 after the edge.
REQ-021 flush_EX=1 SHALL force FSM to IDLE, deassert stall_ID/bubble_EX that cycle, and clear all capture valids; flush overrides hazard.
REQ-022 ex_hold=1 SHALL freeze the FSM counter; stall_ID SHALL also assert while ex_hold=1.
REQ-023 Forwarding paths SHALL be purely combinational (zero latency); only FSM, counter and capture registers are sequential.

Reset
REQ-024 On rst_n=0, FSM SHALL be IDLE, counter 0, capture valids and data 0, stall_ID=0, bubble_EX=0, immediately and asynchronously.
REQ-025 Reset deassertion mid-stall SHALL resume in IDLE with no residual bubble.

Configuration
REQ-026 Macro FWD_WB_EN defined: WB forwarding (REQ-015 WB term) and capture (REQ-020) SHALL be present.
REQ-027 FWD_WB_EN undefined: WB term and capture logic SHALL be removed; register file write-through covers WB; MEM forwarding and load-use FSM unchanged.

Verification
REQ-028 ADD x5 in MEM (alu_MEM=0x11), WB writes x5=0x22, rs_addr_EX[0]=5 -> read_EX_pro[0]=0x11.
REQ-029 LW x7 in EX, rs_addr_ID[1]=7, LOAD_LAT=2 -> stall_ID/bubble_EX high exactly 2 cycles, then low.
REQ-030 rs_addr_EX[0]=0, wen_MEM with rd_MEM=0, alu_MEM=0xFFFF -> read_EX_pro[0]=read_EX[0].
REQ-031 ex_hold=1 for 3 cycles, WB writes x9=0xABCD in cycle 1, rs_addr_EX[1]=9 -> read_EX_pro[1]=0xABCD in cycles 2-3 after WB leaves.
REQ-032 Load-use stall active, flush_EX=1 -> stall_ID=0 same cycle, FSM IDLE next cycle; rst_n=0 mid-stall -> all outputs 0 immediately.
